// File: rtl/kgp_alu_seq.sv
// kgp_alu_seq: IDLE/READ/EXEC/WRITE sequencer driving an external ALU from a register file.
// Define KGP_SEQ_R0_ZERO_EN to make register 0 read as zero and ignore writes to it.
module kgp_alu_seq #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_cmd,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [REG_AW-1:0] instr_rt,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic              instr_use_imm,
    input  logic [31:0]       instr_imm,
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    output logic [3:0]        alu_cmd,
    input  logic [31:0]       alu_z,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [31:0]       wb_data,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              w_accept;
    logic              w_load_ops;
    logic              w_latch_res;
    logic              w_write;
    logic              w_wr_en;

    logic [3:0]        r_cmd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic              r_use_imm;
    logic [31:0]       r_imm;

    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic [3:0]        r_alu_cmd;
    logic [31:0]       r_res;

    logic [31:0]       r_rf [NREG];

    logic [31:0]       w_rs_data;
    logic [31:0]       w_rt_data;

`ifdef KGP_SEQ_R0_ZERO_EN
    assign w_rs_data = (r_rs == '0) ? 32'd0 : r_rf[r_rs];
    assign w_rt_data = (r_rt == '0) ? 32'd0 : r_rf[r_rt];
    assign dbg_data  = (dbg_addr == '0) ? 32'd0 : r_rf[dbg_addr];
    assign w_wr_en   = (r_rd != '0);
`else
    assign w_rs_data = r_rf[r_rs];
    assign w_rt_data = r_rf[r_rt];
    assign dbg_data  = r_rf[dbg_addr];
    assign w_wr_en   = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load_ops  = 1'b0;
        w_latch_res = 1'b0;
        w_write     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_READ;
                end
            end
            S_READ: begin
                w_load_ops = 1'b1;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_latch_res = 1'b1;
                w_next      = S_WRITE;
            end
            S_WRITE: begin
                w_write = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
        end else if (w_accept) begin
            r_cmd     <= instr_cmd;
            r_rs      <= instr_rs;
            r_rt      <= instr_rt;
            r_rd      <= instr_rd;
            r_use_imm <= instr_use_imm;
            r_imm     <= instr_imm;
        end
    end

    // Operand registers double as the ALU drive, so they hold outside EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_alu_cmd <= '0;
        end else if (w_load_ops) begin
            r_op1     <= w_rs_data;
            r_op2     <= r_use_imm ? r_imm : w_rt_data;
            r_alu_cmd <= r_cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_latch_res) begin
            r_res <= alu_z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_write && w_wr_en) begin
            r_rf[r_rd] <= r_res;
        end
    end

    assign instr_ready = (r_state == S_IDLE) && !rst;
    assign busy        = (r_state != S_IDLE);
    assign wb_valid    = (r_state == S_WRITE);
    assign wb_rd       = r_rd;
    assign wb_data     = r_res;
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign alu_cmd     = r_alu_cmd;

endmodule

// File: tb/tb_kgp_alu_seq.sv
// Testbench for kgp_alu_seq: table vectors, corner sequences and random traffic
// checked against an instruction-level register-file model.
module tb_kgp_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_cmd;
    logic [3:0]  instr_rs;
    logic [3:0]  instr_rt;
    logic [3:0]  instr_rd;
    logic        instr_use_imm;
    logic [31:0] instr_imm;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_z;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kgp_alu_seq #(.REG_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_cmd    (instr_cmd),
        .instr_rs     (instr_rs),
        .instr_rt     (instr_rt),
        .instr_rd     (instr_rd),
        .instr_use_imm(instr_use_imm),
        .instr_imm    (instr_imm),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_cmd      (alu_cmd),
        .alu_z        (alu_z),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .busy         (busy),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // External ALU seen by the sequencer.
    function automatic logic [31:0] alu_fn(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b1001: return b;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign alu_z = alu_fn(alu_cmd, alu_op1, alu_op2);

    logic [31:0] m_rf [16];

    function automatic logic [31:0] mread(input logic [3:0] a);
`ifdef KGP_SEQ_R0_ZERO_EN
        if (a == 4'd0) return 32'd0;
`endif
        return m_rf[a];
    endfunction

    task automatic mwrite(input logic [3:0] a, input logic [31:0] d);
`ifdef KGP_SEQ_R0_ZERO_EN
        if (a == 4'd0) return;
`endif
        m_rf[a] = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic run_instr(input vec_t v, input string nm);
        int cyc;
        bit got;
        @(negedge clk);
        instr_valid   = 1'b1;
        instr_cmd     = v.cmd;
        instr_rs      = v.rs;
        instr_rt      = v.rt;
        instr_rd      = v.rd;
        instr_use_imm = v.use_imm;
        instr_imm     = v.imm;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (instr_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk({nm, " accept timeout"}, 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) got = 1'b1;
        end
        chk({nm, " latency"}, 32'(cyc), 32'd4);
        chk({nm, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({nm, " wb_data"}, wb_data, v.exp);
        chk({nm, " alu_cmd hold"}, 32'(alu_cmd), 32'(v.cmd));
        dbg_addr = v.rd;
        #1 chk({nm, " dbg pre"}, dbg_data, mread(v.rd));
        mwrite(v.rd, v.exp);
        @(negedge clk);
        chk({nm, " wb pulse end"}, 32'(wb_valid), 32'd0);
        chk({nm, " dbg post"}, dbg_data, mread(v.rd));
    endtask

    vec_t tbl[7];

    initial begin
        int nready;
        int nbusy_bad;
        int nwb;
        bit got;
        vec_t v;

        tbl[0] = '{4'b1001, 4'd0, 4'd0, 4'd1, 1'b1, 32'd5, 32'd5};
        tbl[1] = '{4'b1001, 4'd0, 4'd0, 4'd2, 1'b1, 32'd7, 32'd7};
        tbl[2] = '{4'b0000, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 32'd12};
        tbl[3] = '{4'b0001, 4'd1, 4'd1, 4'd1, 1'b0, 32'd0, 32'd0};
        tbl[4] = '{4'b0010, 4'd3, 4'd0, 4'd5, 1'b1, 32'hF0F0_000C, 32'h0000_000C};
        tbl[5] = '{4'b1111, 4'd3, 4'd0, 4'd6, 1'b1, 32'd12, 32'hFFFF_FFFF};
        tbl[6] = '{4'b1001, 4'd0, 4'd0, 4'd0, 1'b1, 32'h0000_DEAD, 32'h0000_DEAD};

        for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;

        rst = 1'b1;
        instr_valid = 1'b0;
        instr_cmd = '0;
        instr_rs = '0;
        instr_rt = '0;
        instr_rd = '0;
        instr_use_imm = 1'b0;
        instr_imm = '0;
        dbg_addr = 4'd3;

        @(negedge clk);
        @(negedge clk);
        chk("rst ready", 32'(instr_ready), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst alu_op1", alu_op1, 32'd0);
        chk("rst alu_cmd", 32'(alu_cmd), 32'd0);
        chk("rst dbg", dbg_data, 32'd0);
        rst = 1'b0;
        #1 chk("ready after rst", 32'(instr_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i], $sformatf("vec%0d", i));
        end

        dbg_addr = 4'd0;
        #1;
`ifdef KGP_SEQ_R0_ZERO_EN
        chk("r0 write discarded", dbg_data, 32'd0);
`else
        chk("r0 ordinary", dbg_data, 32'h0000_DEAD);
`endif

        // Back-to-back offers with instr_valid held high.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_cmd = 4'b1001;
        instr_rd = 4'd7;
        instr_use_imm = 1'b1;
        instr_imm = 32'd1;
        nready = 0;
        nbusy_bad = 0;
        nwb = 0;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready) nready++;
            if (busy == instr_ready) nbusy_bad++;
            if (wb_valid) nwb++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("stream ready count", 32'(nready), 32'd4);
        chk("stream busy pattern", 32'(nbusy_bad), 32'd0);
        chk("stream wb count", 32'(nwb), 32'd4);
        mwrite(4'd7, 32'd1);
        dbg_addr = 4'd7;
        #1 chk("stream r7", dbg_data, mread(4'd7));

        // Reset in EXEC abandons the write.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_cmd = 4'b1001;
        instr_rd = 4'd4;
        instr_imm = 32'd9;
        instr_use_imm = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (instr_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("abort accept", 32'(got), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in exec", 32'(busy), 32'd1);
        rst = 1'b1;
        nwb = 0;
        for (int i = 0; i < 2; i++) begin
            #1 if (wb_valid) nwb++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
        #1 chk("abort ready after rst", 32'(instr_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid) nwb++;
        end
        chk("abort no wb", 32'(nwb), 32'd0);
        dbg_addr = 4'd4;
        #1 chk("abort r4", dbg_data, 32'd0);

        for (int i = 0; i < 40; i++) begin
            v.cmd = 4'($urandom_range(0, 15));
            v.rs = 4'($urandom_range(0, 15));
            v.rt = 4'($urandom_range(0, 15));
            v.rd = 4'($urandom_range(0, 15));
            v.use_imm = 1'($urandom_range(0, 1));
            v.imm = $urandom;
            v.exp = alu_fn(v.cmd, mread(v.rs),
                           v.use_imm ? v.imm : mread(v.rt));
            run_instr(v, $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 chk($sformatf("final r%0d", i), dbg_data, mread(4'(i)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/kgp_alu_seq.md
KGP_ALU_SEQ -- requirements
Module: kgp_alu_seq

Interface
REQ-001 SHALL have parameter REG_AW, default 4, giving the register-file address width (2**REG_AW entries of 32 bits).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port instr_valid, input, 1, meaning an instruction is offered.
REQ-005 SHALL have port instr_ready, output, 1, meaning the sequencer accepts an instruction this cycle.
REQ-006 SHALL have port instr_cmd, input, 4, the ALU command code passed unchanged to the ALU.
REQ-007 SHALL have ports instr_rs, instr_rt and instr_rd, input, REG_AW each, holding source 1, source 2 and destination register indices.
REQ-008 SHALL have port instr_use_imm, input, 1; when high, operand2 is taken from instr_imm instead of register rt.
REQ-009 SHALL have port instr_imm, input, 32, the immediate operand.
REQ-010 SHALL have ports alu_op1 and alu_op2, output, 32 each, and alu_cmd, output, 4, which drive the ALU.
REQ-011 SHALL have port alu_z, input, 32, the combinational ALU result.
REQ-012 SHALL have ports wb_valid, output, 1 (one-cycle writeback pulse); wb_rd, output, REG_AW; and wb_data, output, 32.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have ports dbg_addr, input, REG_AW, and dbg_data, output, 32, a combinational register-file read.

Function
REQ-015 SHALL implement the FSM IDLE->READ->EXEC->WRITE->IDLE, advancing one state per clock with no stalls.
REQ-016 SHALL assert instr_ready only in IDLE with rst low; an instruction is accepted on a cycle where instr_valid && instr_ready, and cmd/rs/rt/rd/use_imm/imm are latched on that cycle.
REQ-017 SHALL ignore instr_valid in READ, EXEC and WRITE; the requester holds its instruction until instr_ready is high.
REQ-018 SHALL, in READ, latch op1_q = rf[rs], and op2_q = imm if use_imm else rf[rt].
REQ-019 SHALL, in EXEC, drive alu_op1 = op1_q, alu_op2 = op2_q and alu_cmd = latched cmd, and latch res_q = alu_z at the end of the cycle.
REQ-020 SHALL hold alu_op1, alu_op2 and alu_cmd at their last values outside EXEC.
REQ-021 SHALL, in WRITE, write rf[rd] = res_q, assert wb_valid for exactly that cycle with wb_rd = rd and wb_data = res_q, and return to IDLE.
REQ-022 SHALL have a latency of 4 cycles from the accept edge to the wb_valid cycle, and a maximum throughput of one instruction per 4 cycles.
REQ-023 SHALL make rs = rt = rd legal; reads in READ see the value before this instruction's write.
REQ-024 SHALL have dbg_data return the pre-write value during the WRITE cycle and the new value from the next cycle.
REQ-025 SHALL treat all 16 commands, including 4'b1111, as writing back; results such as division by zero are not checked.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, instr_ready = 0, busy = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, alu_op1 = alu_op2 = 0, alu_cmd = 0, and all register-file entries and internal latches to 0.
REQ-027 SHALL, if rst is asserted mid-instruction, abandon that instruction with no register write and no wb_valid pulse.

Configuration
REQ-028 SHALL support macro KGP_SEQ_R0_ZERO_EN: when defined, register 0 reads as 0 on every read path (including dbg_data), and writes to register 0 are discarded while wb_valid still pulses; when undefined, register 0 is an ordinary register.

Verification
REQ-029 SHALL cover: load R1 (cmd 1001, use_imm, imm=5) then R2 (imm=7), then cmd 0000 rs=1 rt=2 rd=3 -> wb_valid with wb_rd=3, wb_data=12 exactly 4 cycles after accept; dbg_addr=3 reads 12.
REQ-030 SHALL cover: instr_valid held high continuously -> instr_ready high once every 4 cycles, exactly one accept per 4 cycles, busy high in the 3 other cycles.
REQ-031 SHALL cover: R1=5, cmd 0001 rs=1 rt=1 rd=1 -> wb_data=0 and R1=0 afterwards.
REQ-032 SHALL cover: rst pulsed during EXEC of a write to R4=9 -> no wb_valid, R4 reads 0, instr_ready high in the first cycle after rst falls.
REQ-033 SHALL cover: imm=0xDEAD written to rd=0 -> with KGP_SEQ_R0_ZERO_EN, dbg_data=0 and wb_valid=1; without it, dbg_data=0x0000DEAD.
